// File: rtl/opcode_assembler_if.sv
// Command bus between the host byte stream and the opcode assembler.
// The master side drives bytes and core_ready; the slave (assembler) returns issued opcodes and FIFO status.
interface opcode_assembler_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        align;
    logic        core_ready;
    logic [15:0] opcode;
    logic        execute;
    logic        fifo_empty;
    logic        fifo_full;
    logic        overflow;

    modport master (
        output byte_in, byte_valid, align, core_ready,
        input  opcode, execute, fifo_empty, fifo_full, overflow
    );

    modport slave (
        input  byte_in, byte_valid, align, core_ready,
        output opcode, execute, fifo_empty, fifo_full, overflow
    );
endinterface

// File: rtl/opcode_assembler.sv
// Pairs host command bytes into 16-bit opcodes (high byte first), queues them and issues them with spacing.
// Define OPCODE_LEVEL_EN to add the fifo_level occupancy output port.
module opcode_assembler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MIN_GAP = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    opcode_assembler_if.slave        cmd
`ifdef OPCODE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   fifo_level
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

    typedef enum logic {
        ASM_HIGH,
        ASM_LOW
    } asm_state_t;

    asm_state_t        asm_state;
    logic [7:0]        held_byte;
    logic [15:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [GAP_W-1:0]  gap;

    logic              word_done;
    logic              pop_en;
    logic              push_en;
    logic              drop;

    // Pop eligibility uses the pre-edge count, so a word pushed this edge cannot be issued at it.
    always_comb begin
        word_done  = cmd.byte_valid && (asm_state == ASM_LOW) && !cmd.align;
        pop_en     = (count != '0) && cmd.core_ready && (gap == '0);
        push_en    = word_done && ((count != CNT_FULL) || pop_en);
        drop       = word_done && (count == CNT_FULL) && !pop_en;
        count_next = count + CNT_W'(push_en) - CNT_W'(pop_en);
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= {held_byte, cmd.byte_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state      <= ASM_HIGH;
            held_byte      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            gap            <= '0;
            cmd.opcode     <= '0;
            cmd.execute    <= 1'b0;
            cmd.fifo_empty <= 1'b1;
            cmd.fifo_full  <= 1'b0;
            cmd.overflow   <= 1'b0;
        end else begin
            if (cmd.align) begin
                asm_state <= ASM_HIGH;
            end else if (cmd.byte_valid) begin
                if (asm_state == ASM_HIGH) begin
                    held_byte <= cmd.byte_in;
                    asm_state <= ASM_LOW;
                end else begin
                    asm_state <= ASM_HIGH;
                end
            end

            if (cmd.align) begin
                cmd.overflow <= 1'b0;
            end else if (drop) begin
                cmd.overflow <= 1'b1;
            end

            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            if (pop_en) begin
                cmd.opcode  <= mem[rd_ptr];
                cmd.execute <= 1'b1;
                rd_ptr      <= rd_ptr + PTR_W'(1);
                gap         <= GAP_RELOAD;
            end else begin
                cmd.execute <= 1'b0;
                if (gap != '0) begin
                    gap <= gap - GAP_W'(1);
                end
            end

            count          <= count_next;
            cmd.fifo_empty <= (count_next == '0);
            cmd.fifo_full  <= (count_next == CNT_FULL);
        end
    end

`ifdef OPCODE_LEVEL_EN
    assign fifo_level = count;
`endif

endmodule

// File: tb/tb_opcode_assembler.sv
// Randomized and directed bench for opcode_assembler against a queue-based reference model.
// Build with OPCODE_LEVEL_EN defined to also check fifo_level.
module tb_opcode_assembler;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MIN_GAP = 2;

    logic clk;
    logic rst_n;

    opcode_assembler_if cmd ();

`ifdef OPCODE_LEVEL_EN
    logic [$clog2(DEPTH):0] fifo_level;
`endif

    opcode_assembler #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (cmd.slave)
`ifdef OPCODE_LEVEL_EN
        ,
        .fifo_level (fifo_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words, a pending high byte, and issue
    // eligibility expressed as "at least MIN_GAP edges since the last issue".
    logic [15:0] m_q[$];
    bit          m_hf;
    logic [7:0]  m_hb;
    bit          m_ovf;
    logic [15:0] m_op;
    bit          m_exec;
    int          edge_no;
    int          last_exec;

    int          ev_edge[$];
    logic [15:0] ev_op[$];

    task automatic model_reset();
        m_q.delete();
        m_hf      = 1'b0;
        m_hb      = '0;
        m_ovf     = 1'b0;
        m_op      = '0;
        m_exec    = 1'b0;
        edge_no   = 0;
        last_exec = -1000;
    endtask

    task automatic model_edge(input bit bv, input logic [7:0] b, input bit al, input bit rdy);
        int  pre;
        bit  pop;
        edge_no++;
        pre    = m_q.size();
        pop    = (pre > 0) && rdy && ((edge_no - last_exec) >= int'(MIN_GAP));
        m_exec = pop;
        if (pop) begin
            m_op      = m_q.pop_front();
            last_exec = edge_no;
        end
        if (al) begin
            m_hf  = 1'b0;
            m_ovf = 1'b0;
        end else if (bv) begin
            if (!m_hf) begin
                m_hb = b;
                m_hf = 1'b1;
            end else begin
                m_hf = 1'b0;
                if (pre < int'(DEPTH) || pop) m_q.push_back({m_hb, b});
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("opcode",     32'(cmd.opcode),     32'(m_op));
        check("execute",    32'(cmd.execute),    32'(m_exec));
        check("fifo_empty", 32'(cmd.fifo_empty), 32'(m_q.size() == 0));
        check("fifo_full",  32'(cmd.fifo_full),  32'(m_q.size() == int'(DEPTH)));
        check("overflow",   32'(cmd.overflow),   32'(m_ovf));
`ifdef OPCODE_LEVEL_EN
        check("fifo_level", 32'(fifo_level),     32'(m_q.size()));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare 1ns later.
    task automatic cycle(input bit bv, input logic [7:0] b, input bit al, input bit rdy);
        cmd.byte_valid = bv;
        cmd.byte_in    = b;
        cmd.align      = al;
        cmd.core_ready = rdy;
        @(posedge clk);
        model_edge(bv, b, al, rdy);
        #1;
        check_outputs();
        if (cmd.execute) begin
            ev_edge.push_back(edge_no);
            ev_op.push_back(cmd.opcode);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input bit rdy);
        cycle(1'b1, w[15:8], 1'b0, rdy);
        cycle(1'b1, w[7:0],  1'b0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rdy);
    endtask

    initial begin
        cmd.byte_valid = 1'b0;
        cmd.byte_in    = '0;
        cmd.align      = 1'b0;
        cmd.core_ready = 1'b0;
        rst_n          = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_opcode",  32'(cmd.opcode),     32'h0);
        check("rst_execute", 32'(cmd.execute),    32'h0);
        check("rst_empty",   32'(cmd.fifo_empty), 32'h1);
        check("rst_full",    32'(cmd.fifo_full),  32'h0);
        check("rst_ovf",     32'(cmd.overflow),   32'h0);
        #10 rst_n = 1'b1;

        // single opcode, two-edge latency from the second byte
        cycle(1'b1, 8'hA5, 1'b0, 1'b1);
        cycle(1'b1, 8'h3C, 1'b0, 1'b1);
        check("t1_no_exec_yet", 32'(cmd.execute), 32'h0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_exec",   32'(cmd.execute), 32'h1);
        check("t1_opcode", 32'(cmd.opcode),  32'hA53C);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_one_pulse", 32'(cmd.execute),    32'h0);
        check("t1_empty",     32'(cmd.fifo_empty), 32'h1);

        // fill, overflow, then ordered drain at MIN_GAP spacing
        for (int i = 1; i <= 5; i++) begin
            push_word(16'(i), 1'b0);
            if (i == 4) check("t2_full_after4", 32'(cmd.fifo_full), 32'h1);
        end
        check("t2_overflow", 32'(cmd.overflow), 32'h1);
        ev_edge.delete();
        ev_op.delete();
        idle(12, 1'b1);
        check("t2_exec_count", 32'(ev_op.size()), 32'd4);
        for (int i = 0; i < ev_op.size() && i < 4; i++) begin
            check("t2_order", 32'(ev_op[i]), 32'(i + 1));
            if (i > 0) check("t2_spacing", 32'(ev_edge[i] - ev_edge[i-1]), 32'd2);
        end

        // align drops the held byte, clears overflow and wins over a same-cycle byte
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b1, 8'h99, 1'b1, 1'b1);
        check("t3_ovf_clear", 32'(cmd.overflow), 32'h0);
        ev_op.delete();
        ev_edge.delete();
        push_word(16'h2233, 1'b1);
        idle(4, 1'b1);
        check("t3_count", 32'(ev_op.size()), 32'd1);
        if (ev_op.size() > 0) check("t3_opcode", 32'(ev_op[0]), 32'h2233);

        // full FIFO: push and pop on the same edge
        for (int i = 0; i < 4; i++) push_word(16'h0A00 + 16'(i), 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b1, 8'h88, 1'b0, 1'b1);
        check("t4_exec", 32'(cmd.execute),   32'h1);
        check("t4_full", 32'(cmd.fifo_full), 32'h1);
        check("t4_ovf",  32'(cmd.overflow),  32'h0);
        idle(12, 1'b1);

        // async reset mid-opcode with entries queued
        push_word(16'h1234, 1'b0);
        push_word(16'h5678, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("t5_opcode",  32'(cmd.opcode),     32'h0);
        check("t5_execute", 32'(cmd.execute),    32'h0);
        check("t5_empty",   32'(cmd.fifo_empty), 32'h1);
        check("t5_full",    32'(cmd.fifo_full),  32'h0);
        check("t5_ovf",     32'(cmd.overflow),   32'h0);
        #2 rst_n = 1'b1;
        push_word(16'hBEEF, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_exec",     32'(cmd.execute), 32'h1);
        check("t5_beef",     32'(cmd.opcode),  32'hBEEF);
        idle(3, 1'b1);

`ifdef OPCODE_LEVEL_EN
        check("t6_level0", 32'(fifo_level), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            push_word(16'hC000 + 16'(i), 1'b0);
            check("t6_level_up", 32'(fifo_level), 32'(i));
        end
        for (int i = 3; i >= 0; i--) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            check("t6_level_down", 32'(fifo_level), 32'(i));
            cycle(1'b0, 8'h00, 1'b0, 1'b0);
        end
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1);
        end
        idle(20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
